alu_sequencer: RTL

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/seq_pkg.sv | 40 ++++
 rtl/instr_decode.sv | 21 ++
 rtl/alu_sequencer.sv | 106 ++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the ALU sequencer: FSM states, instruction field
// positions, and the ALU operation encodings.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } state_t;

  localparam int INSTR_W = 32;
  localparam int REG_AW  = 5;
  localparam int IMM_W   = 14;

  // Instruction word layout
  localparam int OPC_HI  = 31;
  localparam int OPC_LO  = 30;
  localparam int DST_HI  = 29;
  localparam int DST_LO  = 25;
  localparam int SRC1_HI = 24;
  localparam int SRC1_LO = 20;
  localparam int SRC2_HI = 19;
  localparam int SRC2_LO = 15;
  localparam int LDI_BIT = 14;
  localparam int IMM_HI  = 13;
  localparam int IMM_LO  = 0;

  // ALU operation select values
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  // Load-immediate operands are unsigned, so widen with zeros.
  function automatic logic [INSTR_W-1:0] zext_imm(input logic [IMM_W-1:0] imm);
    return {{(INSTR_W-IMM_W){1'b0}}, imm};
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational field splitter for the latched instruction word.
module instr_decode
  import seq_pkg::*;
(
  input  logic [31:0] word,
  output logic [1:0]  opcode,
  output logic [4:0]  dest,
  output logic [4:0]  src1,
  output logic [4:0]  src2,
  output logic        ldi,
  output logic [13:0] imm
);

  assign opcode = word[OPC_HI:OPC_LO];
  assign dest   = word[DST_HI:DST_LO];
  assign src1   = word[SRC1_HI:SRC1_LO];
  assign src2   = word[SRC2_HI:SRC2_LO];
  assign ldi    = word[LDI_BIT];
  assign imm    = word[IMM_HI:IMM_LO];

endmodule

// File: rtl/alu_sequencer.sv
// Four-state instruction sequencer: accepts one instruction word, presents
// register addresses to the downstream register/ALU stage, captures the
// result (or an immediate) and writes it back, counting retired instructions.
module alu_sequencer
  import seq_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic [31:0]      instr,
  output logic             instr_ready,
  input  logic [31:0]      alu_result,
  output logic [4:0]       a1,
  output logic [4:0]       a2,
  output logic [4:0]       a3,
  output logic [1:0]       opcode,
  output logic             we3,
  output logic [31:0]      wd3,
  output logic             done,
  output logic [CNT_W-1:0] retired
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_t           state;
  state_t           state_nxt;
  logic [31:0]      instr_q;
  logic [31:0]      result_q;
  logic [CNT_W-1:0] retired_q;

  logic [1:0]       dec_opcode;
  logic [4:0]       dec_dest;
  logic [4:0]       dec_src1;
  logic [4:0]       dec_src2;
  logic             dec_ldi;
  logic [13:0]      dec_imm;

  instr_decode u_dec (
    .word   (instr_q),
    .opcode (dec_opcode),
    .dest   (dec_dest),
    .src1   (dec_src1),
    .src2   (dec_src2),
    .ldi    (dec_ldi),
    .imm    (dec_imm)
  );

  // Addresses come straight from the latched word, which only changes on a
  // handshake, so they naturally hold their last values while idle.
  assign a1       = dec_src1;
  assign a2       = dec_src2;
  assign a3       = dec_dest;
  assign opcode   = dec_opcode;
  assign wd3      = result_q;
  assign retired  = retired_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake/write strobes; strobes are gated by rst so an
  // instruction caught in WRITE during reset never writes.
  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    we3         = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = !rst;
        if (instr_valid && !rst) state_nxt = READ;
      end
      READ:  state_nxt = EXEC;
      EXEC:  state_nxt = WRITE;
      WRITE: begin
        we3       = !rst && (dec_dest != 5'd0);
        done      = !rst;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Instruction latch: captured only on an accepted handshake.
  always_ff @(posedge clk) begin
    if (rst)                                instr_q <= '0;
    else if (state == IDLE && instr_valid)  instr_q <= instr;
  end

  // Result register: ALU output or immediate, sampled at the end of EXEC.
  always_ff @(posedge clk) begin
    if (rst)                result_q <= '0;
    else if (state == EXEC) result_q <= dec_ldi ? zext_imm(dec_imm) : alu_result;
  end

  // Retired counter: bumps on leaving WRITE and wraps naturally.
  always_ff @(posedge clk) begin
    if (rst)                 retired_q <= '0;
    else if (state == WRITE) retired_q <= retired_q + CNT_ONE;
  end

endmodule
